// File: rtl/hms_pkg.sv
// Shared encodings and field limits for the hours/minutes/seconds alarm clock.
// Also holds the modulo step helper used by the set-time and set-alarm editors.
package hms_pkg;

    typedef enum logic [1:0] {
        MODE_CLOCK     = 2'd0,
        MODE_SET_TIME  = 2'd1,
        MODE_SET_ALARM = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        POS_SEC  = 2'd0,
        POS_MIN  = 2'd1,
        POS_HOUR = 2'd2
    } pos_t;

    localparam logic [5:0] SEC_MAX  = 6'd59;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [4:0] HOUR_MAX = 5'd23;

    // Wraps inside 0..maxVal with no carry out; up=1 increments, up=0 decrements.
    function automatic logic [5:0] wrapStep(input logic [5:0] val,
                                            input logic [5:0] maxVal,
                                            input logic       up);
        if (up) begin
            return (val >= maxVal) ? 6'd0 : val + 6'd1;
        end
        return (val == 6'd0) ? maxVal : val - 6'd1;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// 1 Hz strobe generator: counts 0..CLK_HZ-1 and emits a registered one-cycle tick.
// i_hold parks the counter at 0 so the next second restarts from a clean phase.
module tick_gen #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_hold,
    output logic o_tick
);

    localparam int                 CNT_W    = $clog2(CLK_HZ);
    localparam logic [CNT_W-1:0]   TERMINAL = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] r_count;
    logic             r_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_tick  <= 1'b0;
        end else if (i_hold) begin
            r_count <= '0;
            r_tick  <= 1'b0;
        end else if (r_count == TERMINAL) begin
            r_count <= '0;
            r_tick  <= 1'b1;
        end else begin
            r_count <= r_count + CNT_W'(1);
            r_tick  <= 1'b0;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/hms_alarm_core.sv
// Alarm clock core: mode/position control, time and alarm setpoint editing,
// time-of-day counting on the 1 Hz tick and the alarm ring timer.
module hms_alarm_core #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int ALARM_SEC = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_mode_pulse,
    input  logic       i_pos_pulse,
    input  logic       i_inc_pulse,
    input  logic       i_dec_pulse,
    input  logic       i_alarm_en,
    input  logic       i_alarm_ack,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [4:0] o_hour,
    output logic [5:0] o_al_min,
    output logic [4:0] o_al_hour,
    output logic [1:0] o_mode,
    output logic [1:0] o_position,
    output logic       o_tick,
    output logic       o_alarm
);
    import hms_pkg::*;

    localparam logic [5:0] RING_LEN = 6'(ALARM_SEC);

    mode_t      r_mode, w_modeNext;
    pos_t       r_pos;
    logic [5:0] r_sec, r_min, r_alMin, r_ringCnt;
    logic [4:0] r_hour, r_alHour;
    logic       r_alarm;
    logic       w_tick, w_inSetTime, w_inSetAlarm, w_runClock;
    logic       w_editOk, w_advance, w_trigger;
    logic [5:0] w_secNext, w_minNext;
    logic [4:0] w_hourNext;

    // The prescaler is held from the very edge that enters SET_TIME, so no tick leaks into it.
    tick_gen #(.CLK_HZ(CLK_HZ)) u_tickGen (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_hold (w_modeNext == MODE_SET_TIME),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_mode <= MODE_CLOCK;
        else        r_mode <= w_modeNext;
    end

    always_comb begin
        w_modeNext = r_mode;
        case (r_mode)
            MODE_CLOCK:     if (i_mode_pulse) w_modeNext = MODE_SET_TIME;
            MODE_SET_TIME:  if (i_mode_pulse) w_modeNext = MODE_SET_ALARM;
            MODE_SET_ALARM: if (i_mode_pulse) w_modeNext = MODE_CLOCK;
            default:        w_modeNext = MODE_CLOCK;
        endcase
    end

    always_comb begin
        w_inSetTime  = (r_mode == MODE_SET_TIME);
        w_inSetAlarm = (r_mode == MODE_SET_ALARM);
        w_runClock   = (r_mode == MODE_CLOCK) || w_inSetAlarm;
    end

    assign w_editOk  = !i_mode_pulse && (i_inc_pulse ^ i_dec_pulse);
    assign w_advance = w_tick && w_runClock;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pos <= POS_SEC;
        end else if (w_modeNext != r_mode) begin
            r_pos <= (w_modeNext == MODE_SET_ALARM) ? POS_MIN : POS_SEC;
        end else if (i_pos_pulse) begin
            if (w_inSetTime)
                r_pos <= (r_pos == POS_SEC) ? POS_MIN : (r_pos == POS_MIN) ? POS_HOUR : POS_SEC;
            else if (w_inSetAlarm)
                r_pos <= (r_pos == POS_MIN) ? POS_HOUR : POS_MIN;
        end
    end

    // Full carry chain in one cycle so 23:59:59 rolls straight to 00:00:00.
    always_comb begin
        w_secNext  = r_sec + 6'd1;
        w_minNext  = r_min;
        w_hourNext = r_hour;
        if (r_sec == SEC_MAX) begin
            w_secNext = 6'd0;
            if (r_min == MIN_MAX) begin
                w_minNext  = 6'd0;
                w_hourNext = (r_hour == HOUR_MAX) ? 5'd0 : r_hour + 5'd1;
            end else begin
                w_minNext = r_min + 6'd1;
            end
        end
    end

    assign w_trigger = w_advance && i_alarm_en && (w_secNext == 6'd0) &&
                       (w_minNext == r_alMin) && (w_hourNext == r_alHour);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sec  <= 6'd0;
            r_min  <= 6'd0;
            r_hour <= 5'd0;
        end else if (w_advance) begin
            r_sec  <= w_secNext;
            r_min  <= w_minNext;
            r_hour <= w_hourNext;
        end else if (w_inSetTime && w_editOk) begin
            case (r_pos)
                POS_SEC:  r_sec  <= wrapStep(r_sec, SEC_MAX, i_inc_pulse);
                POS_MIN:  r_min  <= wrapStep(r_min, MIN_MAX, i_inc_pulse);
                POS_HOUR: r_hour <= 5'(wrapStep({1'b0, r_hour}, {1'b0, HOUR_MAX}, i_inc_pulse));
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alMin  <= 6'd0;
            r_alHour <= 5'd0;
        end else if (w_inSetAlarm && w_editOk) begin
            if (r_pos == POS_MIN)
                r_alMin <= wrapStep(r_alMin, MIN_MAX, i_inc_pulse);
            else if (r_pos == POS_HOUR)
                r_alHour <= 5'(wrapStep({1'b0, r_alHour}, {1'b0, HOUR_MAX}, i_inc_pulse));
        end
    end

    // Ack and disarm beat a same-cycle trigger; a fresh trigger restarts the ring length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ringCnt <= 6'd0;
            r_alarm   <= 1'b0;
        end else if (!i_alarm_en || i_alarm_ack) begin
            r_ringCnt <= 6'd0;
            r_alarm   <= 1'b0;
        end else if (w_trigger) begin
            r_ringCnt <= RING_LEN;
            r_alarm   <= 1'b1;
        end else if (r_alarm && w_tick) begin
            if (r_ringCnt <= 6'd1) begin
                r_ringCnt <= 6'd0;
                r_alarm   <= 1'b0;
            end else begin
                r_ringCnt <= r_ringCnt - 6'd1;
            end
        end
    end

    assign o_sec      = r_sec;
    assign o_min      = r_min;
    assign o_hour     = r_hour;
    assign o_al_min   = r_alMin;
    assign o_al_hour  = r_alHour;
    assign o_mode     = r_mode;
    assign o_position = r_pos;
    assign o_tick     = w_tick;
    assign o_alarm    = r_alarm;

endmodule

// File: tb/tb_hms_alarm_core.sv
// Bench for hms_alarm_core: directed scenarios plus random pulses, all outputs
// compared every cycle against a seconds-of-day reference model.
module tb_hms_alarm_core;

    localparam int CLK_HZ    = 10;
    localparam int ALARM_SEC = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       modePulse = 1'b0, posPulse = 1'b0, incPulse = 1'b0, decPulse = 1'b0;
    logic       alarmEn = 1'b0, alarmAck = 1'b0;
    logic [5:0] outSec, outMin, outAlMin;
    logic [4:0] outHour, outAlHour;
    logic [1:0] outMode, outPos;
    logic       outTick, outAlarm;
    logic [33:0] dutBundle;

    int compareCount = 0;
    int mismatchCount = 0;

    int mMode, mPos, mSecOfDay, mAlarmMinOfDay, mRunCycles, mTick, mRingLeft;

    hms_alarm_core #(.CLK_HZ(CLK_HZ), .ALARM_SEC(ALARM_SEC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_mode_pulse (modePulse),
        .i_pos_pulse  (posPulse),
        .i_inc_pulse  (incPulse),
        .i_dec_pulse  (decPulse),
        .i_alarm_en   (alarmEn),
        .i_alarm_ack  (alarmAck),
        .o_sec        (outSec),
        .o_min        (outMin),
        .o_hour       (outHour),
        .o_al_min     (outAlMin),
        .o_al_hour    (outAlHour),
        .o_mode       (outMode),
        .o_position   (outPos),
        .o_tick       (outTick),
        .o_alarm      (outAlarm)
    );

    always #5 clk = ~clk;

    assign dutBundle = {outSec, outMin, outHour, outAlMin, outAlHour, outMode, outPos, outTick, outAlarm};

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s at %0t: observed 0x%0h expected 0x%0h", tag, $time, observed, expected);
        end
    endtask

    function automatic logic [33:0] expBundle();
        return {6'(mSecOfDay % 60), 6'((mSecOfDay / 60) % 60), 5'(mSecOfDay / 3600),
                6'(mAlarmMinOfDay % 60), 5'(mAlarmMinOfDay / 60),
                2'(mMode), 2'(mPos), 1'(mTick), 1'(mRingLeft > 0)};
    endfunction

    task automatic modelReset();
        mMode = 0; mPos = 0; mSecOfDay = 0; mAlarmMinOfDay = 0;
        mRunCycles = 0; mTick = 0; mRingLeft = 0;
    endtask

    // One clock of behaviour: time as seconds-of-day, alarm as minute-of-day.
    task automatic modelStep(input bit mp, input bit pp, input bit inc, input bit dec,
                             input bit en, input bit ack);
        int  oldMode, newMode, delta, h, m, s;
        bit  tickSeen, editOk, trig;
        oldMode  = mMode;
        tickSeen = (mTick != 0);
        newMode  = mp ? (mMode + 1) % 3 : mMode;
        editOk   = !mp && (inc != dec);
        delta    = inc ? 1 : -1;
        trig     = 1'b0;
        if (oldMode != 1 && tickSeen) begin
            mSecOfDay = (mSecOfDay + 1) % 86400;
            trig = en && (mSecOfDay % 60 == 0) && (mSecOfDay / 60 == mAlarmMinOfDay);
        end else if (oldMode == 1 && editOk) begin
            h = mSecOfDay / 3600; m = (mSecOfDay / 60) % 60; s = mSecOfDay % 60;
            if (mPos == 0) s = (s + delta + 60) % 60;
            if (mPos == 1) m = (m + delta + 60) % 60;
            if (mPos == 2) h = (h + delta + 24) % 24;
            mSecOfDay = h * 3600 + m * 60 + s;
        end
        if (oldMode == 2 && editOk) begin
            h = mAlarmMinOfDay / 60; m = mAlarmMinOfDay % 60;
            if (mPos == 1) m = (m + delta + 60) % 60;
            if (mPos == 2) h = (h + delta + 24) % 24;
            mAlarmMinOfDay = h * 60 + m;
        end
        if (!en || ack)                      mRingLeft = 0;
        else if (trig)                       mRingLeft = ALARM_SEC;
        else if (mRingLeft > 0 && tickSeen)  mRingLeft = mRingLeft - 1;
        if (mp) mPos = (newMode == 2) ? 1 : 0;
        else if (pp && oldMode == 1) mPos = (mPos + 1) % 3;
        else if (pp && oldMode == 2) mPos = (mPos == 1) ? 2 : 1;
        if (newMode == 1) begin
            mRunCycles = 0;
            mTick = 0;
        end else begin
            mRunCycles = mRunCycles + 1;
            mTick = (mRunCycles % CLK_HZ == 0) ? 1 : 0;
        end
        mMode = newMode;
    endtask

    task automatic applyStimulus(input bit mp, input bit pp, input bit inc, input bit dec,
                                 input bit en, input bit ack);
        modePulse = mp; posPulse = pp; incPulse = inc; decPulse = dec;
        alarmEn = en; alarmAck = ack;
        @(posedge clk);
        modelStep(mp, pp, inc, dec, en, ack);
        #1;
        checkOutput("cycleModel", dutBundle, expBundle());
        modePulse = 1'b0; posPulse = 1'b0; incPulse = 1'b0; decPulse = 1'b0; alarmAck = 1'b0;
    endtask

    task automatic runIdle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, alarmEn, 0);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("resetAsync", dutBundle, 34'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Time 00:00:58, alarm 00:01 armed; ends in CLOCK or stays in SET_ALARM.
    task automatic setupAlarm(input bit stayInSetAlarm);
        doReset();
        applyStimulus(1, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 1, 1, 0);
        checkOutput("setupSec58", outSec, 58);
        applyStimulus(1, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 1, 0, 1, 0);
        checkOutput("setupAlarmMin", {outAlHour, outAlMin}, {5'd0, 6'd1});
        if (!stayInSetAlarm) applyStimulus(1, 0, 0, 0, 1, 0);
    endtask

    task automatic waitAlarmRise(output bit found, output bit prevTick);
        found = 1'b0;
        prevTick = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            prevTick = outTick;
            applyStimulus(0, 0, 0, 0, 1, 0);
            found = outAlarm;
        end
        checkOutput("alarmRiseSeen", found, 1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  ticks, highs, cycles;
        bit  found, prevTick;

        modelReset();
        #12;
        checkOutput("resetState", dutBundle, 34'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Editing in SET_TIME: wraps, no carry, prescaler frozen.
        ticks = 0;
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("enterSetTime", {outMode, outPos}, {2'd1, 2'd0});
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("secDecWrap", outSec, 59);
        applyStimulus(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 60; i++) begin
            applyStimulus(0, 0, 1, 0, 0, 0);
            ticks += outTick;
        end
        checkOutput("minInc60Wrap", {outHour, outMin, outSec}, {5'd0, 6'd0, 6'd59});
        for (int i = 0; i < 100; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            ticks += outTick;
        end
        checkOutput("noTickInSetTime", ticks, 0);

        // Force 23:59:58 and let midnight roll over.
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("timeForced", {outHour, outMin, outSec}, {5'd23, 6'd59, 6'd58});
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("enterSetAlarmPos", {outMode, outPos}, {2'd2, 2'd1});
        applyStimulus(1, 0, 0, 0, 0, 0);
        runIdle(18);
        checkOutput("beforeMidnight", {outHour, outMin, outSec}, {5'd23, 6'd59, 6'd59});
        runIdle(1);
        checkOutput("midnightRollover", {outHour, outMin, outSec}, 17'd0);

        // Mode pulse beats a same-cycle inc; inc+dec together does nothing.
        applyStimulus(1, 0, 1, 0, 0, 0);
        checkOutput("modeBeatsInc", {outMode, outHour, outMin, outSec}, {2'd1, 17'd0});
        applyStimulus(0, 0, 1, 1, 0, 0);
        checkOutput("incDecTogether", {outHour, outMin, outSec}, 17'd0);

        // Random pulses against the model.
        doReset();
        alarmEn = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(63) == 0) alarmEn = ~alarmEn;
            applyStimulus($urandom_range(15) == 0, $urandom_range(7) == 0,
                          $urandom_range(3) == 0, $urandom_range(3) == 0,
                          alarmEn, $urandom_range(31) == 0);
        end

        // Alarm rings for ALARM_SEC ticks.
        setupAlarm(0);
        waitAlarmRise(found, prevTick);
        checkOutput("alarmRiseTime", {outHour, outMin, outSec}, {5'd0, 6'd1, 6'd0});
        checkOutput("alarmAfterTick", prevTick, 1);
        ticks = 0;
        cycles = 0;
        while (outAlarm && cycles < 80) begin
            applyStimulus(0, 0, 0, 0, 1, 0);
            if (outAlarm && outTick) ticks++;
            cycles++;
        end
        checkOutput("alarmFell", outAlarm, 0);
        checkOutput("ringTicks", ticks, ALARM_SEC);

        // Ack silences the ring and it does not come back.
        setupAlarm(0);
        waitAlarmRise(found, prevTick);
        runIdle(4);
        checkOutput("stillRinging", outAlarm, 1);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("ackSilences", outAlarm, 0);
        highs = 0;
        for (int i = 0; i < 60; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 0);
            highs += outAlarm;
        end
        checkOutput("noRetrigger", highs, 0);

        // Reset in the middle of a ring in SET_ALARM.
        setupAlarm(1);
        waitAlarmRise(found, prevTick);
        checkOutput("ringInSetAlarm", {outMode, outAlarm}, {2'd2, 1'b1});
        doReset();
        checkOutput("resetMidRing", dutBundle, 34'd0);
        cycles = 0;
        found = 1'b0;
        while (!found && cycles < 30) begin
            applyStimulus(0, 0, 0, 0, 1, 0);
            cycles++;
            found = outTick;
        end
        checkOutput("firstTickAfterReset", cycles, CLK_HZ);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
